inventory_ctrl: RTL and testbench
=================================

Name: inventory_ctrl

Overview:
- Initiator and sequencer for the 4-entry x 4-bit stock RAM of the vending machine. The RAM has a synchronous write and an asynchronous read.
- Holds the RAM's write port (we/addr/data_in) and consumes its data_out.
- Turns host commands (VEND, RESTOCK, QUERY) into read-modify-write sequences and returns the status and the resulting count.
- Fills the RAM with a fixed initial stock after reset.

Parameters:
- ADDR_W, 2, item address width; the RAM depth is 2**ADDR_W.
- DATA_W, 4, stock count width; counts saturate at 2**DATA_W-1.
- INIT_COUNT, 5, stock value written to every location during INIT.
- LOW_THRESH, 1, an item is low when its count <= LOW_THRESH. Used only with LOW_STOCK_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  command: 0=QUERY, 1=VEND, 2=RESTOCK, 3=reserved (treated as QUERY).
- cmd_item  in  ADDR_W  item address.
- cmd_qty  in  DATA_W  quantity for VEND/RESTOCK.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0=OK, 1=SOLD_OUT, 2=SATURATED.
- rsp_count  out  DATA_W  item count after the command.
- init_done  out  1  high once the INIT fill is complete.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; combinational from mem_addr.

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_status=0, rsp_count=0, init_done=0, mem_we=0, mem_addr=0, mem_wdata=0. The state register goes to INIT and the fill counter to 0.
- FSM states: INIT -> IDLE -> RD -> (WR) -> RSP -> IDLE.
- INIT:
  - Each cycle drives mem_we=1, mem_addr=fill counter, mem_wdata=INIT_COUNT.
  - The fill counter increments after each write.
  - After the write to address 2**ADDR_W-1 the FSM goes to IDLE and init_done rises (registered). INIT lasts exactly 2**ADDR_W cycles after reset deasserts.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid && cmd_ready; op, item and qty are latched into registers.
  - Next state is RD. Inputs are ignored when no command is accepted.
- RD:
  - Drives mem_addr=latched item, mem_we=0.
  - Latches mem_rdata into cnt_q.
  - Computes the new value and status from mem_rdata and the latched qty (rules below).
  - Goes to WR if a write is needed, otherwise to RSP.
- WR: drives mem_we=1, mem_addr=item, mem_wdata=new value for exactly one cycle, then goes to RSP.
- RSP: rsp_valid=1 for one cycle with rsp_status and rsp_count, then goes to IDLE. There is no response backpressure.
- Latency, with acceptance at edge 0: a write command pulses rsp_valid in cycle 3; a no-write command pulses it in cycle 2. Throughput is one command per 3 or 4 cycles.
- Arithmetic rules:
  - QUERY: no write; status OK; count = stored value.
  - VEND: if qty > stored, no write, status SOLD_OUT, count = stored. If qty == 0, no write, status OK. Otherwise write stored - qty, status OK. The result never underflows.
  - RESTOCK: form a DATA_W+1-bit sum. If the sum > 2**DATA_W-1, write the maximum and report SATURATED. If qty == 0, no write, status OK. Otherwise write the sum, status OK.
- mem_we is high only in INIT or WR, and never in the same cycle as cmd_ready.
- rst asserted in any state (including mid RD/WR):
  - returns to INIT on the next edge;
  - drops the in-flight command with no rsp_valid;
  - clears init_done;
  - re-fills the RAM. A WR cycle coinciding with rst still reaches the RAM that edge, but INIT overwrites it afterwards.

Optional Feature:
- Macro: INVENTORY_CTRL_LOW_STOCK_EN.
- With the macro: an extra output low_stock [2**ADDR_W-1:0], a registered per-item flag.
  - During INIT each flag is set to (INIT_COUNT <= LOW_THRESH).
  - On every WR cycle the flag for that item is set to (new value <= LOW_THRESH).
  - Reset value: all zeros.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package inventory_pkg holds:
  - the op encodings OP_QUERY/OP_VEND/OP_RESTOCK;
  - the status encodings ST_OK/ST_SOLD_OUT/ST_SATURATED;
  - the FSM state typedef.
- Sub-module stock_alu: purely combinational. Inputs: op, stored count, qty. Outputs: new value, status, write_needed. It is instantiated once, in the RD path.

Test Plan:
- Release rst, then hold 4 cycles -> mem_we=1 with addr 0,1,2,3 and wdata=5 each; init_done=1 on the 5th cycle; QUERY item 2 -> rsp_count=5, status OK, rsp_valid in cycle 2.
- VEND item 1 qty 3 -> RAM[1] written 2, rsp OK/2; VEND item 1 qty 3 again -> no mem_we, rsp SOLD_OUT/2.
- RESTOCK item 0 qty 12 (stored 5) -> RAM[0]=15, rsp SATURATED/15; RESTOCK item 3 qty 4 -> RAM[3]=9, OK/9.
- Back-to-back cmd_valid held high with 3 commands -> cmd_ready low outside IDLE, each command accepted exactly once, responses in order.
- Assert rst during WR of VEND item 2 -> no rsp_valid; INIT repeats; QUERY item 2 returns 5.
- With the macro: VEND item 0 qty 4 (5 -> 1) -> low_stock[0]=1 after the WR edge; RESTOCK item 0 qty 2 -> low_stock[0]=0.

Source files
------------

// File: rtl/inventory_pkg.sv
// rtl/inventory_pkg.sv - command/status encodings and FSM state type for inventory_ctrl
package inventory_pkg;

    localparam logic [1:0] OP_QUERY   = 2'd0;
    localparam logic [1:0] OP_VEND    = 2'd1;
    localparam logic [1:0] OP_RESTOCK = 2'd2;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_SOLD_OUT  = 2'd1;
    localparam logic [1:0] ST_SATURATED = 2'd2;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WR,
        S_RSP
    } state_t;

endpackage

// File: rtl/inventory_ctrl_stock_alu.sv
// rtl/inventory_ctrl_stock_alu.sv - combinational stock arithmetic: new count, status, write request
module stock_alu
    import inventory_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic [DATA_W-1:0] qty_i,
    output logic [DATA_W-1:0] new_val_o,
    output logic [1:0]        status_o,
    output logic              write_needed_o
);

    localparam logic [DATA_W:0] MAX_SUM = {1'b0, {DATA_W{1'b1}}};

    logic [DATA_W:0] sum;

    // Unwritten results report the stored value so the response count is always new_val_o.
    always_comb begin
        sum            = {1'b0, stored_i} + {1'b0, qty_i};
        new_val_o      = stored_i;
        status_o       = ST_OK;
        write_needed_o = 1'b0;
        case (op_i)
            OP_VEND: begin
                if (qty_i > stored_i) begin
                    status_o = ST_SOLD_OUT;
                end else if (qty_i != '0) begin
                    new_val_o      = stored_i - qty_i;
                    write_needed_o = 1'b1;
                end
            end
            OP_RESTOCK: begin
                if (sum > MAX_SUM) begin
                    new_val_o      = {DATA_W{1'b1}};
                    status_o       = ST_SATURATED;
                    write_needed_o = 1'b1;
                end else if (qty_i != '0) begin
                    new_val_o      = sum[DATA_W-1:0];
                    write_needed_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inventory_ctrl.sv
// rtl/inventory_ctrl.sv - stock RAM sequencer (INIT fill, read-modify-write commands); INVENTORY_CTRL_LOW_STOCK_EN adds low_stock flags
module inventory_ctrl
    import inventory_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 4,
    parameter int INIT_COUNT = 5,
    parameter int LOW_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_item,
    input  logic [DATA_W-1:0] cmd_qty,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_count,
    output logic              init_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef INVENTORY_CTRL_LOW_STOCK_EN
    ,
    output logic [(1<<ADDR_W)-1:0] low_stock
`endif
);

    localparam logic [ADDR_W:0]   FILL_END = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] INIT_VAL = DATA_W'(INIT_COUNT);

    state_t              state_q;
    logic [ADDR_W:0]     fill_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   qty_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [1:0]          rsp_status_q;
    logic [DATA_W-1:0]   rsp_count_q;
    logic                init_done_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [DATA_W-1:0]   alu_new;
    logic [1:0]          alu_status;
    logic                alu_wr;

    stock_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i          (op_q),
        .stored_i      (mem_rdata),
        .qty_i         (qty_q),
        .new_val_o     (alu_new),
        .status_o      (alu_status),
        .write_needed_o(alu_wr)
    );

    // Outputs are registered together with the state they belong to, so each
    // state's outputs are visible for exactly the cycle the FSM spends there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            fill_q       <= '0;
            op_q         <= OP_QUERY;
            qty_q        <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_count_q  <= '0;
            init_done_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (fill_q == FILL_END) begin
                        mem_we_q    <= 1'b0;
                        init_done_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= fill_q[ADDR_W-1:0];
                        mem_wdata_q <= INIT_VAL;
                        fill_q      <= fill_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        qty_q       <= cmd_qty;
                        mem_addr_q  <= cmd_item;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_RD;
                    end
                end
                S_RD: begin
                    rsp_status_q <= alu_status;
                    rsp_count_q  <= alu_new;
                    if (alu_wr) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= alu_new;
                        state_q     <= S_WR;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end
                end
                S_WR: begin
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_RSP: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    mem_we_q    <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    init_done_q <= 1'b0;
                    fill_q      <= '0;
                    state_q     <= S_INIT;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_count  = rsp_count_q;
    assign init_done  = init_done_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef INVENTORY_CTRL_LOW_STOCK_EN
    localparam logic [DATA_W-1:0] LOW_VAL  = DATA_W'(LOW_THRESH);
    localparam logic              INIT_LOW = (INIT_COUNT <= LOW_THRESH);

    logic [(1<<ADDR_W)-1:0] low_q;

    // Flags follow every RAM write, so they always describe the stored counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_q <= '0;
        end else if (state_q == S_INIT && fill_q != FILL_END) begin
            low_q[fill_q[ADDR_W-1:0]] <= INIT_LOW;
        end else if (state_q == S_WR) begin
            low_q[mem_addr_q] <= (mem_wdata_q <= LOW_VAL);
        end
    end

    assign low_stock = low_q;
`endif

endmodule

// File: tb/tb_inventory_ctrl.sv
// tb/tb_inventory_ctrl.sv - randomized self-checking bench for inventory_ctrl with a behavioural stock model
module tb_inventory_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int MAXV   = 15;
    localparam int INITV  = 5;
    localparam int LOWT   = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_item;
    logic [DATA_W-1:0] cmd_qty;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [DATA_W-1:0] rsp_count;
    logic              init_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef INVENTORY_CTRL_LOW_STOCK_EN
    logic [DEPTH-1:0]  low_stock;
`endif

    inventory_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_item  (cmd_item),
        .cmd_qty   (cmd_qty),
        .rsp_valid (rsp_valid),
        .rsp_status(rsp_status),
        .rsp_count (rsp_count),
        .init_done (init_done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef INVENTORY_CTRL_LOW_STOCK_EN
        ,
        .low_stock (low_stock)
`endif
    );

    always #5 clk = ~clk;

    // Stock RAM: synchronous write, asynchronous read.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int item;
        int status;
        int count;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   model [DEPTH];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rsp_seen = 0;
    int   we_cnt   = 0;
    int   last_status = -1;
    int   last_count  = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stock rules: vending never underflows, restocking clamps at the maximum.
    function automatic void predict(input int op, input int stored, input int qty,
                                    output int nv, output int st, output int wr);
        nv = stored; st = 0; wr = 0;
        if (op == 1) begin
            if (qty > stored) st = 1;
            else if (qty > 0) begin nv = stored - qty; wr = 1; end
        end else if (op == 2) begin
            if (stored + qty > MAXV) begin nv = MAXV; st = 2; wr = 1; end
            else if (qty > 0) begin nv = stored + qty; wr = 1; end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        check("we_with_ready", int'(mem_we && cmd_ready), 0);
        if (rst) begin
            check("rsp_in_reset", int'(rsp_valid), 0);
        end else begin
            if (mem_we) we_cnt++;
            if (rsp_valid) begin
                rsp_seen++;
                last_status = int'(rsp_status);
                last_count  = int'(rsp_count);
                if (q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rsp_status", int'(rsp_status), e.status);
                    check("rsp_count", int'(rsp_count), e.count);
                    check("rsp_latency", cyc, e.cyc);
                    check("ram_content", int'(ram[e.item]), e.count);
`ifdef INVENTORY_CTRL_LOW_STOCK_EN
                    for (int i = 0; i < DEPTH; i++)
                        check("low_stock_bit", int'(low_stock[i]), int'(model[i] <= LOWT));
`endif
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                check("rsp_late", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high.
    task automatic issue(input int op, input int item, input int qty);
        int k, nv, st, wr, mop;
        exp_t e;
        cmd_op = 2'(op); cmd_item = 2'(item); cmd_qty = 4'(qty); cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 30) begin @(negedge clk); k++; end
        check("ready_timeout", int'(cmd_ready), 1);
        if (cmd_ready) begin
            @(negedge clk);
            check("ready_after_accept", int'(cmd_ready), 0);
            mop = (op == 3) ? 0 : op;
            predict(mop, model[item], qty, nv, st, wr);
            model[item] = nv;
            e.item = item; e.status = st; e.count = nv; e.cyc = cyc + 1 + wr;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin @(negedge clk); k++; end
        check("drain_timeout", q.size(), 0);
    endtask

    task automatic run_lit(input string name, input int op, input int item, input int qty,
                           input int st, input int cnt, input int we_exp);
        int we0;
        we0 = we_cnt;
        issue(op, item, qty);
        cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        check({name, "_status"}, last_status, st);
        check({name, "_count"}, last_count, cnt);
        if (we_exp >= 0) check({name, "_we_cycles"}, we_cnt - we0, we_exp);
    endtask

    // Entered at a negedge with rst already high.
    task automatic do_reset();
        q.delete();
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_status", int'(rsp_status), 0);
        check("rst_rsp_count", int'(rsp_count), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = INITV;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            check("init_we", int'(mem_we), 1);
            check("init_addr", int'(mem_addr), k);
            check("init_wdata", int'(mem_wdata), INITV);
            check("init_done_early", int'(init_done), 0);
        end
        @(negedge clk);
        check("init_done", int'(init_done), 1);
        check("init_ready", int'(cmd_ready), 1);
        check("init_we_off", int'(mem_we), 0);
    endtask

    initial begin
        int s0, k;
        cmd_valid = 1'b0; cmd_op = '0; cmd_item = '0; cmd_qty = '0;
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        run_lit("query2", 0, 2, 7, 0, 5, 0);
        run_lit("vend1", 1, 1, 3, 0, 2, 1);
        run_lit("vend1_sold", 1, 1, 3, 1, 2, 0);
        run_lit("restock0_sat", 2, 0, 12, 2, 15, 1);
        run_lit("restock3", 2, 3, 4, 0, 9, 1);
        run_lit("vend_zero", 1, 2, 0, 0, 5, 0);
        run_lit("reserved_op", 3, 0, 9, 0, 15, 0);

        s0 = rsp_seen;
        issue(2, 1, 1);
        issue(1, 3, 2);
        issue(0, 1, 0);
        cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        check("b2b_rsp_count", rsp_seen - s0, 3);
        check("b2b_last_count", last_count, 3);

        for (int n = 0; n < 300; n++) begin
            int gap;
            issue($urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV));
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                cmd_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);

        run_lit("pre_rst_restock2", 2, 2, 3, int'(model[2] + 3 > MAXV) * 2,
                (model[2] + 3 > MAXV) ? MAXV : model[2] + 3, 1);
        s0 = rsp_seen;
        issue(1, 2, 1);
        cmd_valid = 1'b0;
        k = 0;
        while (!mem_we && k < 5) begin @(negedge clk); k++; end
        check("wr_cycle_seen", int'(mem_we), 1);
        rst = 1'b1;
        do_reset();
        check("rst_dropped_rsp", rsp_seen - s0, 0);
        run_lit("query2_after_rst", 0, 2, 0, 0, 5, 0);

`ifdef INVENTORY_CTRL_LOW_STOCK_EN
        run_lit("low_vend0", 1, 0, 4, 0, 1, 1);
        check("low_stock0_set", int'(low_stock[0]), 1);
        run_lit("low_restock0", 2, 0, 2, 0, 3, 1);
        check("low_stock0_clr", int'(low_stock[0]), 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
